// File: rtl/loop_jump_unit_if.sv
// Issue-stage to loop-jump-unit bus: decoded loop instructions in, fetch
// redirect pulses and loop-stack status out.
interface loop_jump_unit_if #(
  parameter int BITS    = 18,
  parameter int PC_BITS = 16,
  parameter int DEPTH   = 4
);
  localparam int DEPTH_BITS = $clog2(DEPTH + 1);

  logic                  instr_valid;
  logic                  is_loop_start;
  logic                  is_loop_end;
  logic [PC_BITS-1:0]    instr_pc;
  logic [BITS-1:0]       iteration_count;
  logic                  is_inner_independent_loop;

  logic                  jumped;
  logic [PC_BITS-1:0]    jump_target;
  logic                  loop_done;
  logic [DEPTH_BITS-1:0] depth;
  logic [BITS-1:0]       current_iteration;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output instr_valid, is_loop_start, is_loop_end, instr_pc,
           iteration_count, is_inner_independent_loop,
    input  jumped, jump_target, loop_done, depth, current_iteration,
           overflow, underflow
  );

  modport slave (
    input  instr_valid, is_loop_start, is_loop_end, instr_pc,
           iteration_count, is_inner_independent_loop,
    output jumped, jump_target, loop_done, depth, current_iteration,
           overflow, underflow
  );
endinterface

// File: rtl/loop_jump_unit.sv
// Hardware-loop jump sequencer: keeps a stack of nested loop contexts and
// turns each loop_end into either a jump back to the body or a loop exit.
module loop_jump_unit #(
  parameter int BITS                  = 18,
  parameter int SUPERSCALAR_LOG_WIDTH = 2,
  parameter int PC_BITS               = 16,
  parameter int DEPTH                 = 4
) (
  input logic             clk,
  input logic             reset,
  loop_jump_unit_if.slave bus
);
  localparam int DEPTH_BITS = $clog2(DEPTH + 1);
  localparam int IDX_BITS   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH_BITS-1:0] FULL      = DEPTH_BITS'(DEPTH);
  localparam logic [BITS:0]         STEP_ONE  = (BITS + 1)'(1);
  localparam logic [BITS:0]         STEP_WIDE = STEP_ONE << SUPERSCALAR_LOG_WIDTH;

  logic [PC_BITS-1:0]    start_pc_q [DEPTH];
  logic [PC_BITS-1:0]    start_pc_d [DEPTH];
  logic [BITS-1:0]       count_q    [DEPTH];
  logic [BITS-1:0]       count_d    [DEPTH];
  logic [BITS-1:0]       iter_q     [DEPTH];
  logic [BITS-1:0]       iter_d     [DEPTH];
  logic                  indep_q    [DEPTH];
  logic                  indep_d    [DEPTH];
  logic [DEPTH_BITS-1:0] depth_q, depth_d;
  logic                  jumped_q, jumped_d;
  logic [PC_BITS-1:0]    jump_target_q, jump_target_d;
  logic                  loop_done_q, loop_done_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [IDX_BITS-1:0]   top_idx;
  logic [IDX_BITS-1:0]   push_idx;
  logic [BITS:0]         step;
  logic [BITS:0]         next_iter;

  // The increment is one bit wider than the count so a trip count near
  // 2^BITS never wraps back below the limit.
  always_comb begin
    top_idx   = IDX_BITS'(depth_q - 1'b1);
    push_idx  = IDX_BITS'(depth_q);
    step      = indep_q[top_idx] ? STEP_WIDE : STEP_ONE;
    next_iter = {1'b0, iter_q[top_idx]} + step;
  end

  always_comb begin
    start_pc_d    = start_pc_q;
    count_d       = count_q;
    iter_d        = iter_q;
    indep_d       = indep_q;
    depth_d       = depth_q;
    jumped_d      = 1'b0;
    jump_target_d = jump_target_q;
    loop_done_d   = 1'b0;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;

    if (bus.instr_valid) begin
      if (bus.is_loop_end) begin
        if (depth_q == '0) begin
          underflow_d = 1'b1;
        end else if (next_iter < {1'b0, count_q[top_idx]}) begin
          iter_d[top_idx] = next_iter[BITS-1:0];
          jumped_d        = 1'b1;
          jump_target_d   = start_pc_q[top_idx];
        end else begin
          depth_d     = depth_q - 1'b1;
          loop_done_d = 1'b1;
        end
      end else if (bus.is_loop_start) begin
        if (depth_q == FULL) begin
          overflow_d = 1'b1;
        end else begin
          start_pc_d[push_idx] = bus.instr_pc + 1'b1;
          count_d[push_idx]    = bus.iteration_count;
          iter_d[push_idx]     = '0;
          indep_d[push_idx]    = bus.is_inner_independent_loop;
          depth_d              = depth_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        start_pc_q[i] <= '0;
        count_q[i]    <= '0;
        iter_q[i]     <= '0;
        indep_q[i]    <= 1'b0;
      end
      depth_q       <= '0;
      jumped_q      <= 1'b0;
      jump_target_q <= '0;
      loop_done_q   <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      start_pc_q    <= start_pc_d;
      count_q       <= count_d;
      iter_q        <= iter_d;
      indep_q       <= indep_d;
      depth_q       <= depth_d;
      jumped_q      <= jumped_d;
      jump_target_q <= jump_target_d;
      loop_done_q   <= loop_done_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign bus.jumped            = jumped_q;
  assign bus.jump_target       = jump_target_q;
  assign bus.loop_done         = loop_done_q;
  assign bus.depth             = depth_q;
  assign bus.current_iteration = (depth_q == '0) ? '0 : iter_q[top_idx];
  assign bus.overflow          = overflow_q;
  assign bus.underflow         = underflow_q;

endmodule

// File: tb/tb_loop_jump_unit.sv
// Scoreboard bench for loop_jump_unit: directed instructions push hand-computed
// expectations; a monitor pops and compares one entry per clock.
module tb_loop_jump_unit;
  logic clk;
  logic reset;

  loop_jump_unit_if #(.BITS(18), .PC_BITS(16), .DEPTH(4)) bus ();

  loop_jump_unit #(
    .BITS(18), .SUPERSCALAR_LOG_WIDTH(2), .PC_BITS(16), .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic        jumped;
    logic [15:0] target;
    logic        done;
    logic [2:0]  depth;
    logic [17:0] iter;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic j, logic [15:0] t, logic d, logic [2:0] dep,
                              logic [17:0] it, logic o, logic u);
    exp_t e;
    e.jumped = j; e.target = t; e.done = d; e.depth = dep;
    e.iter = it; e.ovf = o; e.unf = u;
    return e;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", nm, fld, got, want);
    end
  endtask

  task automatic checkOutput(input string nm, input exp_t ex, input logic withTarget);
    cmp(nm, "jumped", 32'(bus.jumped), 32'(ex.jumped));
    cmp(nm, "loop_done", 32'(bus.loop_done), 32'(ex.done));
    cmp(nm, "depth", 32'(bus.depth), 32'(ex.depth));
    cmp(nm, "current_iteration", 32'(bus.current_iteration), 32'(ex.iter));
    cmp(nm, "overflow", 32'(bus.overflow), 32'(ex.ovf));
    cmp(nm, "underflow", 32'(bus.underflow), 32'(ex.unf));
    if (withTarget) cmp(nm, "jump_target", 32'(bus.jump_target), 32'(ex.target));
  endtask

  task automatic applyStimulus(input string nm, input logic v, input logic s,
                               input logic e, input logic [15:0] pc,
                               input logic [17:0] cnt, input logic ind,
                               input exp_t ex);
    @(negedge clk);
    bus.instr_valid               = v;
    bus.is_loop_start             = s;
    bus.is_loop_end               = e;
    bus.instr_pc                  = pc;
    bus.iteration_count           = cnt;
    bus.is_inner_independent_loop = ind;
    expQ.push_back(ex);
    nameQ.push_back(nm);
  endtask

  // Async reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic doReset(input string nm);
    @(negedge clk);
    bus.instr_valid   = 1'b0;
    bus.is_loop_start = 1'b0;
    bus.is_loop_end   = 1'b0;
    #2 reset = 1'b1;
    #1 checkOutput(nm, mk(0, 16'd0, 0, 3'd0, 18'd0, 0, 0), 1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t  ex;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && expQ.size() > 0) begin
        ex = expQ.pop_front();
        nm = nameQ.pop_front();
        checkOutput(nm, ex, ex.jumped);
      end
    end
  end

  initial begin : stimulus
    reset                         = 1'b1;
    bus.instr_valid               = 1'b0;
    bus.is_loop_start             = 1'b0;
    bus.is_loop_end               = 1'b0;
    bus.instr_pc                  = '0;
    bus.iteration_count           = '0;
    bus.is_inner_independent_loop = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset state", mk(0, 16'd0, 0, 3'd0, 18'd0, 0, 0), 1'b1);
    reset = 1'b0;

    // Simple loop; the second loop_end also has is_loop_start set.
    applyStimulus("simple start", 1, 1, 0, 16'd10, 18'd3, 0, mk(0, 0, 0, 1, 0, 0, 0));
    applyStimulus("simple end1", 1, 0, 1, 16'd12, 18'd0, 0, mk(1, 16'd11, 0, 1, 1, 0, 0));
    applyStimulus("simple both", 1, 1, 1, 16'd99, 18'd7, 0, mk(1, 16'd11, 0, 1, 2, 0, 0));
    applyStimulus("simple exit", 1, 0, 1, 16'd12, 18'd0, 0, mk(0, 0, 1, 0, 0, 0, 0));
    applyStimulus("idle", 0, 0, 1, 16'd12, 18'd0, 0, mk(0, 0, 0, 0, 0, 0, 0));

    applyStimulus("indep12 start", 1, 1, 0, 16'd20, 18'd12, 1, mk(0, 0, 0, 1, 0, 0, 0));
    applyStimulus("indep12 end1", 1, 0, 1, 16'd25, 18'd0, 0, mk(1, 16'd21, 0, 1, 4, 0, 0));
    applyStimulus("indep12 end2", 1, 0, 1, 16'd25, 18'd0, 0, mk(1, 16'd21, 0, 1, 8, 0, 0));
    applyStimulus("indep12 exit", 1, 0, 1, 16'd25, 18'd0, 0, mk(0, 0, 1, 0, 0, 0, 0));

    applyStimulus("indep13 start", 1, 1, 0, 16'd30, 18'd13, 1, mk(0, 0, 0, 1, 0, 0, 0));
    applyStimulus("indep13 end1", 1, 0, 1, 16'd35, 18'd0, 0, mk(1, 16'd31, 0, 1, 4, 0, 0));
    applyStimulus("indep13 end2", 1, 0, 1, 16'd35, 18'd0, 0, mk(1, 16'd31, 0, 1, 8, 0, 0));
    applyStimulus("indep13 end3", 1, 0, 1, 16'd35, 18'd0, 0, mk(1, 16'd31, 0, 1, 12, 0, 0));
    applyStimulus("indep13 exit", 1, 0, 1, 16'd35, 18'd0, 0, mk(0, 0, 1, 0, 0, 0, 0));

    applyStimulus("nest outer", 1, 1, 0, 16'd0, 18'd2, 0, mk(0, 0, 0, 1, 0, 0, 0));
    applyStimulus("nest inner", 1, 1, 0, 16'd5, 18'd2, 0, mk(0, 0, 0, 2, 0, 0, 0));
    applyStimulus("nest inner jump", 1, 0, 1, 16'd7, 18'd0, 0, mk(1, 16'd6, 0, 2, 1, 0, 0));
    applyStimulus("nest inner exit", 1, 0, 1, 16'd7, 18'd0, 0, mk(0, 0, 1, 1, 0, 0, 0));
    applyStimulus("nest outer jump", 1, 0, 1, 16'd8, 18'd0, 0, mk(1, 16'd1, 0, 1, 1, 0, 0));
    applyStimulus("nest outer exit", 1, 0, 1, 16'd8, 18'd0, 0, mk(0, 0, 1, 0, 0, 0, 0));

    applyStimulus("count0 start", 1, 1, 0, 16'd40, 18'd0, 0, mk(0, 0, 0, 1, 0, 0, 0));
    applyStimulus("count0 exit", 1, 0, 1, 16'd41, 18'd0, 0, mk(0, 0, 1, 0, 0, 0, 0));
    applyStimulus("count1 start", 1, 1, 0, 16'd41, 18'd1, 0, mk(0, 0, 0, 1, 0, 0, 0));
    applyStimulus("count1 exit", 1, 0, 1, 16'd42, 18'd0, 0, mk(0, 0, 1, 0, 0, 0, 0));

    // 2^18-1 with step 4: 65536 passes, last iteration index 262140.
    applyStimulus("max start", 1, 1, 0, 16'd50, 18'h3FFFF, 1, mk(0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 65535; k++)
      applyStimulus("max jump", 1, 0, 1, 16'd52, 18'd0, 0,
                    mk(1, 16'd51, 0, 1, 18'(4 * k), 0, 0));
    applyStimulus("max exit", 1, 0, 1, 16'd52, 18'd0, 0, mk(0, 0, 1, 0, 0, 0, 0));

    applyStimulus("mid start1", 1, 1, 0, 16'd0, 18'd5, 0, mk(0, 0, 0, 1, 0, 0, 0));
    applyStimulus("mid start2", 1, 1, 0, 16'd8, 18'd5, 0, mk(0, 0, 0, 2, 0, 0, 0));
    applyStimulus("mid jump", 1, 0, 1, 16'd9, 18'd0, 0, mk(1, 16'd9, 0, 2, 1, 0, 0));
    doReset("reset mid-loop");
    applyStimulus("post-reset end", 1, 0, 1, 16'd9, 18'd0, 0, mk(0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 5; i++)
      applyStimulus("overflow push", 1, 1, 0, 16'(60 + i), 18'd5, 0,
                    mk(0, 0, 0, (i < 4) ? 3'(i + 1) : 3'd4, 0, (i == 4), 1));

    doReset("reset before underflow");
    for (int i = 0; i < 5; i++)
      applyStimulus("underflow end", 1, 0, 1, 16'd70, 18'd0, 0, mk(0, 0, 0, 0, 0, 0, 1));
    applyStimulus("final idle", 0, 0, 0, 16'd0, 18'd0, 0, mk(0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    checks++;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
